out_argmax: RTL and testbench

- Sits directly downstream of the output-layer neurons.
- Collects the N_OUT neuron results, each arriving on its own neu_out/neu_rdy pair with skewed timing.
- Once all results are in, scans them sequentially and reports the winning class index and value as a steady, level-held result.
- Includes a completion timeout so a stuck neuron is flagged instead of hanging the classifier.

---
 rtl/out_argmax.sv | 94 +++++++++
 tb/tb_out_argmax.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/out_argmax.sv
// out_argmax: collects skewed output-neuron results, scans them for the largest and holds the winner
module out_argmax #(
    parameter int N_OUT   = 10,
    parameter int DW      = 32,
    parameter int IW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic [N_OUT*DW-1:0] neu_out,
    input  logic [N_OUT-1:0]    neu_rdy,
    output logic [IW-1:0]       cls_idx,
    output logic [DW-1:0]       cls_val,
    output logic                cls_rdy,
    output logic                cls_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {COLLECT, SCAN, DONE, ERR} state_t;
    state_t           state_q;
    logic [N_OUT-1:0] cap_q, cap_d;
    logic [DW-1:0]    val_q [N_OUT];
    logic [TW-1:0]    tmo_q;
    logic [IW-1:0]    cnt_q, best_idx_q, win_idx;
    logic [DW-1:0]    best_val_q, win_val;
    logic             bigger;
    // Capture mask after this edge and the running best including the slot under scan (strictly greater keeps the lowest index on ties)
    always_comb begin
        cap_d   = cap_q | neu_rdy;
        bigger  = val_q[cnt_q] > best_val_q;
        win_idx = bigger ? cnt_q : best_idx_q;
        win_val = bigger ? val_q[cnt_q] : best_val_q;
    end
    // Collect with timeout, sequential scan, then hold the result until clr restarts everything like reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= COLLECT;
            cap_q      <= '0;
            tmo_q      <= '0;
            cnt_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            for (int i = 0; i < N_OUT; i++) val_q[i] <= '0;
            cls_idx    <= '0;
            cls_val    <= '0;
            cls_rdy    <= 1'b0;
            cls_err    <= 1'b0;
        end else if (clr) begin
            state_q    <= COLLECT;
            cap_q      <= '0;
            tmo_q      <= '0;
            cnt_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            for (int i = 0; i < N_OUT; i++) val_q[i] <= '0;
            cls_idx    <= '0;
            cls_val    <= '0;
            cls_rdy    <= 1'b0;
            cls_err    <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (&cap_q) begin
                        state_q    <= SCAN;
                        best_val_q <= val_q[0];
                        best_idx_q <= '0;
                        cnt_q      <= IW'(1);
                    end else begin
                        for (int i = 0; i < N_OUT; i++)
                            if (neu_rdy[i] && !cap_q[i]) val_q[i] <= neu_out[i*DW +: DW];
                        cap_q <= cap_d;
                        if (|cap_q) tmo_q <= tmo_q + 1'b1;
                        if (|cap_q && !(&cap_d) && tmo_q == TW'(TIMEOUT - 1)) begin
                            state_q <= ERR;
                            cls_err <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    best_idx_q <= win_idx;
                    best_val_q <= win_val;
                    cnt_q      <= (cnt_q == IW'(N_OUT - 1)) ? cnt_q : cnt_q + 1'b1;
                    if (cnt_q == IW'(N_OUT - 1)) begin
                        cls_idx <= win_idx;
                        cls_val <= win_val;
                        cls_rdy <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_out_argmax.sv
// tb_out_argmax: directed and randomized checks of out_argmax against an argmax reference
module tb_out_argmax;
    localparam int N   = 10;
    localparam int DW  = 32;
    localparam int IW  = 4;
    localparam int TMO = 16;
    typedef logic [DW-1:0] word_t;
    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            clr = 1'b0;
    logic [N*DW-1:0] neu_out = '0;
    logic [N-1:0]    neu_rdy = '0;
    logic [IW-1:0]   cls_idx;
    logic [DW-1:0]   cls_val;
    logic            cls_rdy, cls_err;
    int              n_cmp = 0;
    int              n_bad = 0;
    word_t           v [N];
    int              arr [N];
    int              b;

    out_argmax #(.N_OUT(N), .DW(DW), .IW(IW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .clr(clr), .neu_out(neu_out), .neu_rdy(neu_rdy),
        .cls_idx(cls_idx), .cls_val(cls_val), .cls_rdy(cls_rdy), .cls_err(cls_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic r, input logic e, input int idx, input word_t val);
        chk($sformatf("%s.rdy", tag), word_t'(cls_rdy), word_t'(r));
        chk($sformatf("%s.err", tag), word_t'(cls_err), word_t'(e));
        chk($sformatf("%s.idx", tag), word_t'(cls_idx), word_t'(idx));
        chk($sformatf("%s.val", tag), cls_val, val);
    endtask

    // Reference: first index holding the largest unsigned value
    function automatic int ref_idx(input word_t a [N]);
        int k = 0;
        for (int i = 1; i < N; i++) if (a[i] > a[k]) k = i;
        return k;
    endfunction

    // Restart, present each result on its arrival cycle (scrambling it once captured), check latency and winner
    task automatic run_case(input word_t a [N], input int t [N], input string tag);
        int last = 0;
        int w;
        for (int i = 0; i < N; i++) if (t[i] > last) last = t[i];
        clr = 1'b1;
        neu_rdy = '0;
        tick();
        clr = 1'b0;
        for (int c = 0; c <= last; c++) begin
            for (int i = 0; i < N; i++) begin
                if (t[i] == c) begin
                    neu_out[i*DW +: DW] = a[i];
                    neu_rdy[i] = 1'b1;
                end else if (t[i] < c) begin
                    neu_out[i*DW +: DW] = $urandom;
                end
            end
            tick();
        end
        repeat (N - 1) tick();
        chk_out($sformatf("%s.pre", tag), 1'b0, 1'b0, 0, '0);
        tick();
        w = ref_idx(a);
        chk_out(tag, 1'b1, 1'b0, w, a[w]);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) neu_out[i*DW +: DW] = $urandom;
            neu_rdy = N'($urandom);
            tick();
        end
        chk_out("reset", 1'b0, 1'b0, 0, '0);
        neu_rdy = '0;
        reset = 1'b1;
        repeat (40) tick();
        chk_out("idle", 1'b0, 1'b0, 0, '0);

        for (int i = 0; i < N; i++) begin
            v[i] = word_t'(32'h10 * (i + 1));
            arr[i] = 0;
        end
        v[7] = 32'hA0;
        run_case(v, arr, "simul");
        repeat (30) tick();
        chk_out("simul.hold", 1'b1, 1'b0, 7, 32'hA0);

        for (int i = 0; i < N; i++) begin
            v[i] = word_t'(32'h10 * i);
            arr[i] = N - 1 - i;
        end
        v[2] = 32'hFF;
        v[5] = 32'hFF;
        run_case(v, arr, "tie");
        chk("tie.idx2", word_t'(cls_idx), word_t'(2));

        clr = 1'b1;
        neu_rdy = '0;
        tick();
        clr = 1'b0;
        for (int i = 0; i < N; i++) begin
            v[i] = $urandom;
            neu_out[i*DW +: DW] = v[i];
        end
        neu_rdy[N-2:0] = '1;
        tick();
        repeat (TMO - 1) tick();
        chk_out("tmo.before", 1'b0, 1'b0, 0, '0);
        tick();
        chk_out("tmo.edge", 1'b0, 1'b1, 0, '0);
        neu_rdy[N-1] = 1'b1;
        repeat (5) tick();
        chk_out("tmo.hold", 1'b0, 1'b1, 0, '0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_out("tmo.clr", 1'b0, 1'b0, 0, '0);
        tick();
        repeat (N - 1) tick();
        chk_out("tmo.re.pre", 1'b0, 1'b0, 0, '0);
        tick();
        b = ref_idx(v);
        chk_out("tmo.re", 1'b1, 1'b0, b, v[b]);

        for (int i = 0; i < N; i++) begin
            v[i] = $urandom;
            arr[i] = 0;
        end
        arr[N-1] = TMO;
        run_case(v, arr, "bound");

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                v[i] = $urandom_range(0, 1) ? word_t'($urandom_range(0, 15)) : word_t'($urandom);
                arr[i] = $urandom_range(0, 12);
            end
            v[$urandom_range(0, N - 1)] = v[$urandom_range(0, N - 1)];
            run_case(v, arr, $sformatf("rand%0d", r));
        end

        clr = 1'b1;
        neu_rdy = '0;
        tick();
        clr = 1'b0;
        for (int i = 0; i < N; i++) neu_out[i*DW +: DW] = $urandom;
        neu_rdy = '1;
        tick();
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        chk_out("scanrst", 1'b0, 1'b0, 0, '0);
        neu_rdy = '0;
        tick();
        tick();
        reset = 1'b1;
        repeat (N + 5) tick();
        chk_out("scanrst.after", 1'b0, 1'b0, 0, '0);

        for (int i = 0; i < N; i++) begin
            v[i] = $urandom_range(0, 31);
            arr[i] = $urandom_range(0, 5);
        end
        run_case(v, arr, "preclr");
        for (int i = 0; i < N; i++) neu_out[i*DW +: DW] = v[i];
        b = ref_idx(v);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_out("done.clr", 1'b0, 1'b0, 0, '0);
        repeat (N) tick();
        chk_out("done.re.pre", 1'b0, 1'b0, 0, '0);
        tick();
        chk_out("done.re", 1'b1, 1'b0, b, v[b]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
